// File: rtl/pwm_pkg.sv
// Shared widths, scheduler state encoding and the write-path range check.
package pwm_pkg;

  localparam int unsigned WIDTH_DEF  = 17;
  localparam int unsigned HRBITS_DEF = 3;
  localparam int unsigned NCH_DEF    = 2;

  // Compare width: WIDTH carries one spare bit above the compare value.
  function automatic int unsigned cw_of(input int unsigned width);
    return width - 1;
  endfunction

  // Coarse timebase width: compare width minus the sub-clock bits.
  function automatic int unsigned tbw_of(input int unsigned width, input int unsigned hrbits);
    return width - hrbits - 1;
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned chw_of(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } sched_state_t;

  // Both coarse edges must land inside the period they will run under.
  function automatic logic range_ok(input int unsigned h_coarse,
                                    input int unsigned l_coarse,
                                    input int unsigned pn);
    return (h_coarse <= pn) && (l_coarse <= pn);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Coarse timebase: counts 0..period while enabled, strobes wrap on the return to 0.
module pwm_timebase #(
  parameter int unsigned TBW = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [TBW-1:0] period,
  output logic [TBW-1:0] tb,
  output logic           wrap
);

  logic [TBW-1:0] tb_q, tb_d;
  logic           wrap_q, wrap_d;

  // Next count and wrap strobe; the count holds while disabled.
  always_comb begin
    tb_d   = tb_q;
    wrap_d = 1'b0;
    if (en) begin
      wrap_d = (tb_q == period);
      tb_d   = (tb_q == period) ? '0 : tb_q + TBW'(1);
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tb_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      tb_q   <= tb_d;
      wrap_q <= wrap_d;
    end
  end

  assign tb   = tb_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/pwm_cmp_sched.sv
// Compare-value scheduler: shadows host writes and commits whole sets at a period wrap.
module pwm_cmp_sched
  import pwm_pkg::*;
#(
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned HRBITS = HRBITS_DEF,
  parameter  int unsigned NCH    = NCH_DEF,
  localparam int unsigned CW     = cw_of(WIDTH),
  localparam int unsigned TBW    = tbw_of(WIDTH, HRBITS),
  localparam int unsigned CHW    = chw_of(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CW-1:0]     cfg_cmpH,
  input  logic [CW-1:0]     cfg_cmpL,
  input  logic [TBW-1:0]    cfg_period,
  input  logic              cfg_last,
  output logic [TBW-1:0]    tb,
  output logic [NCH*CW-1:0] cmpH,
  output logic [NCH*CW-1:0] cmpL,
  output logic              wrap,
  output logic              committed,
  output logic              err
);

  sched_state_t   state_q, state_d;
  logic [CW-1:0]  act_h_q [NCH];
  logic [CW-1:0]  act_h_d [NCH];
  logic [CW-1:0]  act_l_q [NCH];
  logic [CW-1:0]  act_l_d [NCH];
  logic [CW-1:0]  sh_h_q  [NCH];
  logic [CW-1:0]  sh_h_d  [NCH];
  logic [CW-1:0]  sh_l_q  [NCH];
  logic [CW-1:0]  sh_l_d  [NCH];
  logic [TBW-1:0] per_q, per_d;
  logic [TBW-1:0] sh_per_q, sh_per_d;
  logic           committed_q, committed_d;
  logic           err_q, err_d;
  logic           xfer_c;
  logic           write_ok_c;
  logic           commit_c;
  logic [TBW-1:0] pn_c;

  // Shared timebase runs off the active period only.
  pwm_timebase #(
    .TBW(TBW)
  ) u_timebase (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (per_q),
    .tb     (tb),
    .wrap   (wrap)
  );

  // Handshake, range check, shadow update and commit decision.
  always_comb begin
    state_d     = state_q;
    act_h_d     = act_h_q;
    act_l_d     = act_l_q;
    sh_h_d      = sh_h_q;
    sh_l_d      = sh_l_q;
    per_d       = per_q;
    sh_per_d    = sh_per_q;
    committed_d = 1'b0;
    err_d       = 1'b0;

    cfg_ready   = (state_q != ARMED);
    xfer_c      = cfg_valid && cfg_ready;
    pn_c        = cfg_last ? cfg_period : sh_per_q;
    write_ok_c  = range_ok(32'(cfg_cmpH[CW-1:HRBITS]), 32'(cfg_cmpL[CW-1:HRBITS]), 32'(pn_c))
                  && (32'(cfg_ch) < NCH);
    commit_c    = (state_q == ARMED) && (!en || (tb == per_q));

    case (state_q)
      IDLE, LOAD: begin
        if (xfer_c) begin
          if (write_ok_c) begin
            sh_h_d[cfg_ch] = cfg_cmpH;
            sh_l_d[cfg_ch] = cfg_cmpL;
            if (cfg_last) begin
              sh_per_d = cfg_period;
              state_d  = ARMED;
            end else begin
              state_d  = LOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARMED: begin
        if (commit_c) begin
          act_h_d     = sh_h_q;
          act_l_d     = sh_l_q;
          per_d       = sh_per_q;
          committed_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, active set, shadow set and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_h_q     <= '{default: '0};
      act_l_q     <= '{default: '0};
      sh_h_q      <= '{default: '0};
      sh_l_q      <= '{default: '0};
      per_q       <= '1;
      sh_per_q    <= '1;
      committed_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_h_q     <= act_h_d;
      act_l_q     <= act_l_d;
      sh_h_q      <= sh_h_d;
      sh_l_q      <= sh_l_d;
      per_q       <= per_d;
      sh_per_q    <= sh_per_d;
      committed_q <= committed_d;
      err_q       <= err_d;
    end
  end

  // Flatten the active pairs onto the channel buses.
  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign cmpH[k*CW +: CW] = act_h_q[k];
    assign cmpL[k*CW +: CW] = act_l_q[k];
  end

  assign committed = committed_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pwm_cmp_sched.sv
// Self-checking bench for pwm_cmp_sched: vector table plus hand sequences, scoreboard-compared.
module tb_pwm_cmp_sched;

  localparam int unsigned CW  = 16;
  localparam int unsigned TBW = 13;

  logic            clk = 1'b0;
  logic            rst, en, cfg_valid, cfg_last;
  logic            cfg_ready;
  logic [0:0]      cfg_ch;
  logic [CW-1:0]   cfg_cmpH, cfg_cmpL;
  logic [TBW-1:0]  cfg_period;
  logic [TBW-1:0]  tb;
  logic [2*CW-1:0] cmpH, cmpL;
  logic            wrap, committed, err;

  always #5 clk = ~clk;

  pwm_cmp_sched dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_cmpH   (cfg_cmpH),
    .cfg_cmpL   (cfg_cmpL),
    .cfg_period (cfg_period),
    .cfg_last   (cfg_last),
    .tb         (tb),
    .cmpH       (cmpH),
    .cmpL       (cmpL),
    .wrap       (wrap),
    .committed  (committed),
    .err        (err)
  );

  typedef struct {
    logic           rst, en, valid, ch, last;
    logic [CW-1:0]  h, l;
    logic [TBW-1:0] per;
  } stim_t;

  // cm packs {ch0 H, ch0 L, ch1 H, ch1 L}.
  typedef struct packed {
    logic [TBW-1:0] tb;
    logic           wrap, comm, err, rdy;
    logic [63:0]    cm;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
    string tag;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] SA = {16'h0008, 16'h0018, 16'h0020, 16'h0038};
  localparam logic [63:0] SB = {16'h0010, 16'h0030, 16'h0040, 16'h0078};
  localparam logic [63:0] SC = {16'h0018, 16'h0020, 16'h0040, 16'h0078};
  localparam logic [63:0] SD = {16'h0028, 16'h0030, 16'h0040, 16'h0078};
  localparam logic [63:0] SE = {16'h0028, 16'h0030, 16'h0048, 16'h0050};

  function automatic stim_t idle(input logic en_i, input logic rst_i = 1'b0);
    stim_t s;
    s.rst = rst_i; s.en = en_i; s.valid = 1'b0; s.ch = 1'b0; s.last = 1'b0;
    s.h = '0; s.l = '0; s.per = '0;
    return s;
  endfunction

  function automatic stim_t wr(input logic en_i, input logic ch_i, input logic [CW-1:0] h_i,
                               input logic [CW-1:0] l_i, input logic [TBW-1:0] per_i,
                               input logic last_i);
    stim_t s;
    s.rst = 1'b0; s.en = en_i; s.valid = 1'b1; s.ch = ch_i; s.last = last_i;
    s.h = h_i; s.l = l_i; s.per = per_i;
    return s;
  endfunction

  function automatic exp_t ex(input int t, input logic w, input logic c, input logic e,
                              input logic r, input logic [63:0] cm);
    exp_t x;
    x.tb = TBW'(t); x.wrap = w; x.comm = c; x.err = e; x.rdy = r; x.cm = cm;
    return x;
  endfunction

  task automatic add(input stim_t s, input exp_t e, input string tag);
    vec_t v;
    v.s = s; v.e = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Drive one cycle, expect the state seen after the following edge.
  task automatic step(input stim_t s, input exp_t e, input string tag);
    exp_t got, want;
    rst = s.rst; en = s.en; cfg_valid = s.valid; cfg_ch = s.ch; cfg_last = s.last;
    cfg_cmpH = s.h; cfg_cmpL = s.l; cfg_period = s.per;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got.tb = tb; got.wrap = wrap; got.comm = committed; got.err = err; got.rdy = cfg_ready;
    got.cm = {cmpH[15:0], cmpL[15:0], cmpH[31:16], cmpL[31:16]};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got tb=%0d wrap=%b committed=%b err=%b ready=%b cmp=%h; required tb=%0d wrap=%b committed=%b err=%b ready=%b cmp=%h",
               tag, got.tb, got.wrap, got.comm, got.err, got.rdy, got.cm,
               want.tb, want.wrap, want.comm, want.err, want.rdy, want.cm);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_last = 1'b0;
    cfg_cmpH = '0; cfg_cmpL = '0; cfg_period = '0;

    // Reset, then a stopped-timebase commit of P=7.
    add(idle(1'b0, 1'b1), ex(0, 0, 0, 0, 1, Z), "reset0");
    add(idle(1'b0, 1'b1), ex(0, 0, 0, 0, 1, Z), "reset1");
    add(wr(1'b0, 1'b0, 16'h0008, 16'h0018, 13'd0, 1'b0), ex(0, 0, 0, 0, 1, Z), "a_load_ch0");
    add(wr(1'b0, 1'b1, 16'h0020, 16'h0038, 13'd7, 1'b1), ex(0, 0, 0, 0, 0, Z), "a_arm_ch1");
    add(idle(1'b0), ex(0, 0, 1, 0, 1, SA), "a_stopped_commit");
    // Timebase runs 0..7 and wraps.
    for (int i = 1; i <= 7; i++) add(idle(1'b1), ex(i, 0, 0, 0, 1, SA), "p7_count");
    add(idle(1'b1), ex(0, 1, 0, 0, 1, SA), "p7_wrap");
    add(idle(1'b1), ex(1, 0, 0, 0, 1, SA), "p7_after_wrap");
    add(idle(1'b0), ex(1, 0, 0, 0, 1, SA), "hold0");
    add(idle(1'b0), ex(1, 0, 0, 0, 1, SA), "hold1");
    // Atomic running commit of both channels plus P=15.
    add(wr(1'b0, 1'b0, 16'h0010, 16'h0030, 13'd0, 1'b0), ex(1, 0, 0, 0, 1, SA), "b_load_ch0");
    add(wr(1'b1, 1'b1, 16'h0040, 16'h0078, 13'd15, 1'b1), ex(2, 0, 0, 0, 0, SA), "b_arm_ch1");
    for (int i = 3; i <= 7; i++) add(idle(1'b1), ex(i, 0, 0, 0, 0, SA), "b_armed_wait");
    add(idle(1'b1), ex(0, 1, 1, 0, 1, SB), "b_commit_at_wrap");
    for (int i = 1; i <= 15; i++) add(idle(1'b1), ex(i, 0, 0, 0, 1, SB), "p15_count");
    add(idle(1'b1), ex(0, 1, 0, 0, 1, SB), "p15_wrap");
    for (int i = 1; i <= 15; i++) add(idle(1'b1), ex(i, 0, 0, 0, 1, SB), "p15_count2");
    // Arming on the tb==P edge must wait a full period.
    add(wr(1'b1, 1'b0, 16'h0018, 16'h0020, 13'd15, 1'b1), ex(0, 1, 0, 0, 0, SB), "c_arm_at_end");
    for (int i = 1; i <= 15; i++) add(idle(1'b1), ex(i, 0, 0, 0, 0, SB), "c_armed_wait");
    add(idle(1'b1), ex(0, 1, 1, 0, 1, SC), "c_commit");
    // Range rejects: H coarse 16 on a last write, L coarse 16 against shadow P.
    add(wr(1'b0, 1'b1, 16'h0080, 16'h0010, 13'd15, 1'b1), ex(0, 0, 0, 1, 1, SC), "r_reject_h");
    add(wr(1'b0, 1'b0, 16'h0000, 16'h0080, 13'd0, 1'b0), ex(0, 0, 0, 1, 1, SC), "r_reject_l");
    add(idle(1'b0), ex(0, 0, 0, 0, 1, SC), "r_err_clears");
    for (int i = 1; i <= 15; i++) add(idle(1'b1), ex(i, 0, 0, 0, 1, SC), "r_period_kept");
    add(idle(1'b1), ex(0, 1, 0, 0, 1, SC), "r_wrap_no_commit");

    foreach (vecs[i]) step(vecs[i].s, vecs[i].e, vecs[i].tag);

    // Held-off write: valid stays up through ARMED and lands after the commit.
    step(wr(1'b0, 1'b0, 16'h0028, 16'h0030, 13'd15, 1'b1), ex(0, 0, 0, 0, 0, SC), "h_arm");
    step(wr(1'b0, 1'b1, 16'h0048, 16'h0050, 13'd0, 1'b0), ex(0, 0, 1, 0, 1, SD), "h_held_commit");
    step(wr(1'b0, 1'b1, 16'h0048, 16'h0050, 13'd0, 1'b0), ex(0, 0, 0, 0, 1, SD), "h_accept");
    step(wr(1'b0, 1'b0, 16'h0028, 16'h0030, 13'd15, 1'b1), ex(0, 0, 0, 0, 0, SD), "h_rearm");
    step(idle(1'b0), ex(0, 0, 1, 0, 1, SE), "h_no_loss");

    // Reset while ARMED, one cycle before tb==P: pending set must never appear.
    step(wr(1'b1, 1'b1, 16'h0070, 16'h0078, 13'd15, 1'b1), ex(1, 0, 0, 0, 0, SE), "x_arm");
    for (int i = 2; i <= 14; i++) step(idle(1'b1), ex(i, 0, 0, 0, 0, SE), "x_armed_wait");
    step(idle(1'b1, 1'b1), ex(0, 0, 0, 0, 1, Z), "x_reset");
    for (int i = 1; i <= 20; i++) step(idle(1'b1), ex(i, 0, 0, 0, 1, Z), "x_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
